// File: rtl/axi2mem_tcdm_rd_unit_mp.sv
// Multi-lane AXI-to-TCDM read unit: per-lane command FIFO, credit-limited
// single-word TCDM reads, response buffer and id/last tagged data output.
// Ports (per lane i, flattened as lane-major vectors):
//   trans_rd_*    : read command in (req/add/id/last) and gnt out
//   tcdm_*        : TCDM request out (req/add/we/wdata/be), gnt and r_* in
//   data_rd_*     : buffered read beat out (req/dat/id/last), gnt in
//   lane_idle_o   : no queued command and no credit in use

module axi2mem_tcdm_rd_unit_mp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] cnt_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop_i) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  // Storage is cleared too so the outputs read zero right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;
endmodule

module axi2mem_tcdm_rd_unit_mp #(
  parameter int NB_PORTS        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 6,
  parameter int CMD_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_PORTS-1:0]              trans_rd_req_i,
  input  logic [NB_PORTS*ADDR_WIDTH-1:0]   trans_rd_add_i,
  input  logic [NB_PORTS*ID_WIDTH-1:0]     trans_rd_id_i,
  input  logic [NB_PORTS-1:0]              trans_rd_last_i,
  output logic [NB_PORTS-1:0]              trans_rd_gnt_o,
  output logic [NB_PORTS-1:0]              tcdm_req_o,
  output logic [NB_PORTS*ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic [NB_PORTS-1:0]              tcdm_we_o,
  output logic [NB_PORTS*DATA_WIDTH-1:0]   tcdm_wdata_o,
  output logic [NB_PORTS*DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic [NB_PORTS-1:0]              tcdm_gnt_i,
  input  logic [NB_PORTS*DATA_WIDTH-1:0]   tcdm_r_rdata_i,
  input  logic [NB_PORTS-1:0]              tcdm_r_valid_i,
  output logic [NB_PORTS-1:0]              data_rd_req_o,
  output logic [NB_PORTS*DATA_WIDTH-1:0]   data_rd_dat_o,
  output logic [NB_PORTS*ID_WIDTH-1:0]     data_rd_id_o,
  output logic [NB_PORTS-1:0]              data_rd_last_o,
  input  logic [NB_PORTS-1:0]              data_rd_gnt_i,
  output logic [NB_PORTS-1:0]              lane_idle_o
);
  localparam int CRW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int CMW = ID_WIDTH + 1 + ADDR_WIDTH;
  localparam int MW  = ID_WIDTH + 1;

  assign tcdm_we_o    = '0;
  assign tcdm_wdata_o = '0;
  assign tcdm_be_o    = '1;

  for (genvar i = 0; i < NB_PORTS; i++) begin : g_lane
    logic [CMW-1:0]        cmd_in, cmd_head;
    logic [CCW-1:0]        cmd_cnt;
    logic [MW-1:0]         meta_head;
    logic [CRW-1:0]        meta_cnt, resp_cnt;
    logic [CRW-1:0]        credits_q, credits_d;
    logic [DATA_WIDTH-1:0] resp_head;
    logic cmd_push, cmd_empty, cmd_full;
    logic issue, resp_push, out_pop, resp_empty;

    assign cmd_in = {trans_rd_id_i[i*ID_WIDTH +: ID_WIDTH],
                     trans_rd_last_i[i],
                     trans_rd_add_i[i*ADDR_WIDTH +: ADDR_WIDTH]};

    assign cmd_full   = (cmd_cnt == CCW'(CMD_DEPTH));
    assign cmd_empty  = (cmd_cnt == '0);
    assign cmd_push   = trans_rd_req_i[i] && !cmd_full;
    assign tcdm_req_o[i] = !cmd_empty &&
                           (credits_q < CRW'(MAX_OUTSTANDING));
    assign issue      = tcdm_req_o[i] && tcdm_gnt_i[i];

    // meta_cnt tracks granted-but-unconsumed reads; a response is
    // only accepted while some grant is still unanswered.
    assign resp_push  = tcdm_r_valid_i[i] && (meta_cnt > resp_cnt);
    assign resp_empty = (resp_cnt == '0);
    assign out_pop    = !resp_empty && data_rd_gnt_i[i];

    axi2mem_tcdm_rd_unit_mp_fifo #(
      .W(CMW), .DEPTH(CMD_DEPTH)
    ) u_cmd (
      .clk_i, .rst_i,
      .push_i(cmd_push), .data_i(cmd_in),
      .pop_i(issue), .data_o(cmd_head), .cnt_o(cmd_cnt)
    );

    axi2mem_tcdm_rd_unit_mp_fifo #(
      .W(MW), .DEPTH(MAX_OUTSTANDING)
    ) u_meta (
      .clk_i, .rst_i,
      .push_i(issue), .data_i(cmd_head[CMW-1:ADDR_WIDTH]),
      .pop_i(out_pop), .data_o(meta_head), .cnt_o(meta_cnt)
    );

    axi2mem_tcdm_rd_unit_mp_fifo #(
      .W(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING)
    ) u_resp (
      .clk_i, .rst_i,
      .push_i(resp_push),
      .data_i(tcdm_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i(out_pop), .data_o(resp_head), .cnt_o(resp_cnt)
    );

    always_comb begin
      credits_d = credits_q + CRW'(issue) - CRW'(out_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) credits_q <= '0;
      else       credits_q <= credits_d;
    end

    assign trans_rd_gnt_o[i] = !cmd_full;
    assign tcdm_add_o[i*ADDR_WIDTH +: ADDR_WIDTH] =
      cmd_head[ADDR_WIDTH-1:0];
    assign data_rd_req_o[i] = !resp_empty;
    assign data_rd_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = resp_head;
    assign data_rd_id_o[i*ID_WIDTH +: ID_WIDTH] = meta_head[MW-1:1];
    assign data_rd_last_o[i] = meta_head[0];
    assign lane_idle_o[i] = cmd_empty && (credits_q == '0);
  end
endmodule
